// File: rtl/maze_world_model_if.sv
// -----------------------------------------------------------------------------
// maze_world_model_if
//
// Purpose : command / sense link between the wall-following controller and
//           the maze world model.
//
// Signals :
//   step          controller -> world   advance enable, one command per cycle
//   front         controller -> world   move forward one cell
//   turn          controller -> world   rotate 90 degrees clockwise
//   front_sensor  world -> controller   cell ahead blocked or off-grid
//   left_sensor   world -> controller   cell to the left blocked or off-grid
//
// Modports: master = controller side, slave = world model side.
// -----------------------------------------------------------------------------
interface maze_world_model_if;
    logic step;
    logic front;
    logic turn;
    logic front_sensor;
    logic left_sensor;

    modport master (
        output step,
        output front,
        output turn,
        input  front_sensor,
        input  left_sensor
    );

    modport slave (
        input  step,
        input  front,
        input  turn,
        output front_sensor,
        output left_sensor
    );
endinterface

// File: rtl/maze_world_model.sv
// -----------------------------------------------------------------------------
// maze_world_model
//
// Purpose : closed-loop environment for the wall-following robot controller.
//           Tracks robot position and heading on a 2^XW x 2^YW grid, executes
//           the controller's front/turn commands and feeds the front/left
//           sensors back. Counts moves and bumps, flags goal arrival and
//           front+turn protocol violations.
//
// Ports   :
//   clk           in   sole clock, rising edge
//   reset         in   asynchronous, active-high reset
//   wall_map      in   2^(XW+YW) bits, 1 = blocked; bit index y*2^XW + x
//   cmd           slave modport of maze_world_model_if (step/front/turn in,
//                      front_sensor/left_sensor out)
//   pos_x, pos_y  out  current position
//   heading       out  0 = N (y+1), 1 = E (x+1), 2 = S (y-1), 3 = W (x-1)
//   move_count    out  successful moves, wraps
//   bump_count    out  forward commands into a blocked cell, saturates at 255
//   goal_reached  out  sticky; freezes all state until reset
//   proto_err     out  sticky; front and turn both high on an executed step
//
// Configuration:
//   MAZE_WRAP_EN  defined   -> toroidal grid, edges are never walls
//                 undefined -> grid edges behave as walls
// -----------------------------------------------------------------------------
module maze_world_model #(
    parameter int         XW        = 3,
    parameter int         YW        = 3,
    parameter int         START_X   = 0,
    parameter int         START_Y   = 0,
    parameter logic [1:0] START_DIR = 2'd0,
    parameter int         GOAL_X    = 7,
    parameter int         GOAL_Y    = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [(1<<(XW+YW))-1:0]  wall_map,
    maze_world_model_if.slave        cmd,
    output logic [XW-1:0]            pos_x,
    output logic [YW-1:0]            pos_y,
    output logic [1:0]               heading,
    output logic [15:0]              move_count,
    output logic [7:0]               bump_count,
    output logic                     goal_reached,
    output logic                     proto_err
);

    localparam int NCELL = 1 << (XW + YW);

    localparam logic [XW-1:0] START_XL = XW'(START_X);
    localparam logic [YW-1:0] START_YL = YW'(START_Y);
    localparam logic [XW-1:0] GOAL_XL  = XW'(GOAL_X);
    localparam logic [YW-1:0] GOAL_YL  = YW'(GOAL_Y);
    localparam logic          START_AT_GOAL = (START_XL == GOAL_XL) && (START_YL == GOAL_YL);

    localparam logic [XW:0] X_ONE = (XW+1)'(1);
    localparam logic [YW:0] Y_ONE = (YW+1)'(1);

    typedef struct packed {
        logic          blocked;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } target_t;

    // Neighbouring cell in direction dir. The step is taken one bit wider than
    // the coordinate so that leaving the grid shows up in the extra MSB (carry
    // past the top edge or borrow below zero). The low bits are the wrapped
    // coordinate, which is exactly the torus position.
    function automatic target_t probe(input logic [XW-1:0]    x,
                                      input logic [YW-1:0]    y,
                                      input logic [1:0]       dir,
                                      input logic [NCELL-1:0] map);
        target_t     t;
        logic [XW:0] ex;
        logic [YW:0] ey;
        ex = {1'b0, x};
        ey = {1'b0, y};
        case (dir)
            2'd0:    ey = ey + Y_ONE;
            2'd1:    ex = ex + X_ONE;
            2'd2:    ey = ey - Y_ONE;
            default: ex = ex - X_ONE;
        endcase
        t.x = ex[XW-1:0];
        t.y = ey[YW-1:0];
`ifdef MAZE_WRAP_EN
        t.blocked = map[{t.y, t.x}];
`else
        t.blocked = ex[XW] | ey[YW] | map[{t.y, t.x}];
`endif
        return t;
    endfunction

    logic [XW-1:0] pos_x_q,        pos_x_d;
    logic [YW-1:0] pos_y_q,        pos_y_d;
    logic [1:0]    heading_q,      heading_d;
    logic [15:0]   move_count_q,   move_count_d;
    logic [7:0]    bump_count_q,   bump_count_d;
    logic          goal_reached_q, goal_reached_d;
    logic          proto_err_q,    proto_err_d;

    target_t fwd;
    target_t lft;

    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        pos_x_d        = pos_x_q;
        pos_y_d        = pos_y_q;
        heading_d      = heading_q;
        move_count_d   = move_count_q;
        bump_count_d   = bump_count_q;
        proto_err_d    = proto_err_q;

        fwd = probe(pos_x_q, pos_y_q, heading_q, wall_map);
        lft = probe(pos_x_q, pos_y_q, heading_q - 2'd1, wall_map);

        if (cmd.step && !goal_reached_q) begin
            if (cmd.turn) begin
                // Turn has priority; a simultaneous front is a protocol error.
                heading_d = heading_q + 2'd1;
                if (cmd.front) begin
                    proto_err_d = 1'b1;
                end
            end else if (cmd.front) begin
                if (fwd.blocked) begin
                    if (bump_count_q != 8'hFF) begin
                        bump_count_d = bump_count_q + 8'd1;
                    end
                end else begin
                    pos_x_d      = fwd.x;
                    pos_y_d      = fwd.y;
                    move_count_d = move_count_q + 16'd1;
                end
            end
        end

        goal_reached_d = goal_reached_q | ((pos_x_d == GOAL_XL) && (pos_y_d == GOAL_YL));
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_x_q        <= START_XL;
            pos_y_q        <= START_YL;
            heading_q      <= START_DIR;
            move_count_q   <= '0;
            bump_count_q   <= '0;
            goal_reached_q <= START_AT_GOAL;
            proto_err_q    <= 1'b0;
        end else begin
            pos_x_q        <= pos_x_d;
            pos_y_q        <= pos_y_d;
            heading_q      <= heading_d;
            move_count_q   <= move_count_d;
            bump_count_q   <= bump_count_d;
            goal_reached_q <= goal_reached_d;
            proto_err_q    <= proto_err_d;
        end
    end

    assign cmd.front_sensor = fwd.blocked;
    assign cmd.left_sensor  = lft.blocked;

    assign pos_x        = pos_x_q;
    assign pos_y        = pos_y_q;
    assign heading      = heading_q;
    assign move_count   = move_count_q;
    assign bump_count   = bump_count_q;
    assign goal_reached = goal_reached_q;
    assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_maze_world_model.sv
// -----------------------------------------------------------------------------
// tb_maze_world_model
//
// Self-checking bench for maze_world_model (default 8x8 grid, start (0,0) N,
// goal (7,7)). A behavioural model in plain integer arithmetic tracks the
// robot; one compare process checks every DUT output against it on each
// falling edge. Directed sequences pin the model with literal expectations,
// then randomized maps and commands run against the model.
// Honours MAZE_WRAP_EN for the edge behaviour.
// -----------------------------------------------------------------------------
module tb_maze_world_model;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int GX = 7;
    localparam int GY = 7;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] wall_map = '0;
    logic [2:0]  pos_x;
    logic [2:0]  pos_y;
    logic [1:0]  heading;
    logic [15:0] move_count;
    logic [7:0]  bump_count;
    logic        goal_reached;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    maze_world_model_if cmd_if ();

    maze_world_model dut (
        .clk          (clk),
        .reset        (reset),
        .wall_map     (wall_map),
        .cmd          (cmd_if),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .heading      (heading),
        .move_count   (move_count),
        .bump_count   (bump_count),
        .goal_reached (goal_reached),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_x, m_y, m_d, m_moves, m_bumps;
    bit m_goal, m_perr;

    // Cell one step from (x,y) in direction d: returns 1 if blocked, plus the
    // cell coordinates (wrapped when the grid is a torus).
    function automatic bit m_target(input int x, input int y, input int d,
                                    output int nx, output int ny);
        bit off;
        nx = x;
        ny = y;
        case (d)
            0: ny = y + 1;
            1: nx = x + 1;
            2: ny = y - 1;
            default: nx = x - 1;
        endcase
        off = (nx < 0) || (nx >= W) || (ny < 0) || (ny >= H);
        nx = (nx + W) % W;
        ny = (ny + H) % H;
`ifdef MAZE_WRAP_EN
        return wall_map[ny*W + nx];
`else
        return off || wall_map[ny*W + nx];
`endif
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_x = 0; m_y = 0; m_d = 0;
            m_moves = 0; m_bumps = 0;
            m_goal = (GX == 0) && (GY == 0);
            m_perr = 0;
        end else if (cmd_if.step && !m_goal) begin
            int nx, ny;
            if (cmd_if.turn) begin
                m_d = (m_d + 1) % 4;
                if (cmd_if.front) m_perr = 1;
            end else if (cmd_if.front) begin
                if (m_target(m_x, m_y, m_d, nx, ny)) begin
                    if (m_bumps < 255) m_bumps = m_bumps + 1;
                end else begin
                    m_x = nx;
                    m_y = ny;
                    m_moves = (m_moves + 1) % 65536;
                end
            end
            if (m_x == GX && m_y == GY) m_goal = 1;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        int nx, ny;
        check("pos_x",        pos_x,        m_x);
        check("pos_y",        pos_y,        m_y);
        check("heading",      heading,      m_d);
        check("move_count",   move_count,   m_moves);
        check("bump_count",   bump_count,   m_bumps);
        check("goal_reached", goal_reached, m_goal);
        check("proto_err",    proto_err,    m_perr);
        check("front_sensor", cmd_if.front_sensor, m_target(m_x, m_y, m_d, nx, ny));
        check("left_sensor",  cmd_if.left_sensor,  m_target(m_x, m_y, (m_d + 3) % 4, nx, ny));
    end

    // ---------------- stimulus helpers ----------------
    // Inputs change 1 time unit after a rising edge and stay put until the next.
    task automatic cycle(input bit s, input bit f, input bit t);
        cmd_if.step  = s;
        cmd_if.front = f;
        cmd_if.turn  = t;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [63:0] map);
        cmd_if.step  = 1'b0;
        cmd_if.front = 1'b0;
        cmd_if.turn  = 1'b0;
        #3;
        reset = 1'b1;
        wall_map = map;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        cmd_if.step  = 1'b0;
        cmd_if.front = 1'b0;
        cmd_if.turn  = 1'b0;
        #2;
        do_reset(64'h0);

        // Reset state and three forward moves on an empty map.
        check("rst_pos_y", pos_y, 0);
        check("rst_heading", heading, 0);
`ifdef MAZE_WRAP_EN
        check("rst_left_sensor", cmd_if.left_sensor, 0);
`else
        check("rst_left_sensor", cmd_if.left_sensor, 1);
`endif
        repeat (3) cycle(1, 1, 0);
        check("fwd3_pos_x", pos_x, 0);
        check("fwd3_pos_y", pos_y, 3);
        check("fwd3_moves", move_count, 3);
        check("fwd3_front_sensor", cmd_if.front_sensor, 0);

        // step=0 holds everything.
        cycle(0, 1, 0);
        check("hold_pos_y", pos_y, 3);

        // Four turns walk the heading 1,2,3,0.
        for (int i = 1; i <= 4; i++) begin
            cycle(1, 0, 1);
            check("turn_heading", heading, i % 4);
        end
        check("turn_pos_y", pos_y, 3);

        // front+turn: turn wins, proto_err sticky.
        cycle(1, 1, 1);
        check("perr_heading", heading, 1);
        check("perr_pos_y", pos_y, 3);
        check("perr_flag", proto_err, 1);
        repeat (3) cycle(1, 0, 1);
        cycle(1, 1, 0);
        check("perr_sticky", proto_err, 1);

        // Top edge from (0,7) facing N.
        do_reset(64'h0);
        repeat (7) cycle(1, 1, 0);
        check("edge_pos_y", pos_y, 7);
`ifdef MAZE_WRAP_EN
        check("edge_front_sensor", cmd_if.front_sensor, 0);
        cycle(1, 1, 0);
        check("wrap_pos_y", pos_y, 0);
        check("wrap_moves", move_count, 8);
`else
        check("edge_front_sensor", cmd_if.front_sensor, 1);
        cycle(1, 1, 0);
        check("edge_pos_y_after", pos_y, 7);
        check("edge_bumps", bump_count, 1);
`endif

        // Bump counter saturation against a wall at (0,1).
        do_reset(64'h100);
        repeat (300) cycle(1, 1, 0);
        check("sat_bumps", bump_count, 255);
        check("sat_moves", move_count, 0);
        check("sat_front_sensor", cmd_if.front_sensor, 1);

        // Drive to the goal, then confirm freeze and asynchronous reset.
        do_reset(64'h0);
        repeat (7) cycle(1, 1, 0);
        cycle(1, 0, 1);
        repeat (6) cycle(1, 1, 0);
        check("pre_goal_flag", goal_reached, 0);
        cycle(1, 1, 0);
        check("goal_flag", goal_reached, 1);
        check("goal_pos_x", pos_x, 7);
        check("goal_pos_y", pos_y, 7);
        cycle(1, 1, 0);
        cycle(1, 0, 1);
        cycle(1, 1, 1);
        check("frozen_pos_x", pos_x, 7);
        check("frozen_heading", heading, 1);
        check("frozen_moves", move_count, 14);
        check("frozen_perr", proto_err, 0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_pos_x", pos_x, 0);
        check("async_rst_pos_y", pos_y, 0);
        check("async_rst_heading", heading, 0);
        check("async_rst_moves", move_count, 0);
        check("async_rst_goal", goal_reached, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Randomized maps and command streams against the model.
        for (int m = 0; m < 8; m++) begin
            logic [63:0] map;
            map = {$urandom, $urandom} & {$urandom, $urandom};
            map[0] = 1'b0;
            do_reset(map);
            for (int c = 0; c < 400; c++) begin
                int r;
                bit s, f, t;
                r = $urandom_range(0, 15);
                s = ($urandom_range(0, 3) != 0);
                f = (r < 9) || (r == 15);
                t = (r >= 9) && (r <= 12) || (r == 15);
                cycle(s, f, t);
            end
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
